mod12_share_arbiter: RTL and testbench

MOD12_SHARE_ARBITER -- requirements
Module: mod12_share_arbiter

---
 rtl/mod12_share_arbiter.sv | 113 +++++++++++
 tb/tb_mod12_share_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mod12_share_arbiter.sv
// Two-requester arbiter for a shared modulo-MOD counter: the winner loads a start
// value and step count, the counter runs, and a one-cycle done pulse ends the grant.
module mod12_share_arbiter #(
  parameter int MOD = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] din0,
  input  logic [3:0] din1,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       busy,
  output logic [3:0] count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_nx;
  logic [3:0] rem, rem_nx, count_nx;
  logic       pri, pri_nx;
  logic       gnt0_nx, gnt1_nx, done0_nx, done1_nx, busy_nx;
  logic       sel1;
  logic [3:0] len_sel;

  function automatic logic [3:0] mod_reduce(input logic [3:0] v);
    return 4'({1'b0, v} % 5'(MOD));
  endfunction

  function automatic logic [3:0] wrap_inc(input logic [3:0] c);
    return (c == 4'(MOD - 1)) ? 4'd0 : c + 4'd1;
  endfunction

  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    count_nx = count;
    pri_nx   = pri;
    gnt0_nx  = gnt0;
    gnt1_nx  = gnt1;
    busy_nx  = busy;
    done0_nx = 1'b0;
    done1_nx = 1'b0;
    // Requester 1 wins when it is alone or when both ask and it holds priority.
    sel1     = req1 & (~req0 | pri);
    len_sel  = sel1 ? len1 : len0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          gnt0_nx  = ~sel1;
          gnt1_nx  = sel1;
          busy_nx  = 1'b1;
          count_nx = mod_reduce(sel1 ? din1 : din0);
          rem_nx   = len_sel;
          if (len_sel == 4'd0) begin
            state_nx = DONE;
            done0_nx = ~sel1;
            done1_nx = sel1;
          end else begin
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        count_nx = wrap_inc(count);
        rem_nx   = rem - 4'd1;
        if (rem == 4'd1) begin
          state_nx = DONE;
          done0_nx = gnt0;
          done1_nx = gnt1;
        end
      end
      DONE: begin
        gnt0_nx  = 1'b0;
        gnt1_nx  = 1'b0;
        busy_nx  = 1'b0;
        pri_nx   = gnt0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      rem   <= 4'd0;
      count <= 4'd0;
      pri   <= 1'b0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
      count <= count_nx;
      pri   <= pri_nx;
      gnt0  <= gnt0_nx;
      gnt1  <= gnt1_nx;
      done0 <= done0_nx;
      done1 <= done1_nx;
      busy  <= busy_nx;
    end
  end

endmodule

// File: tb/tb_mod12_share_arbiter.sv
// Directed bench for mod12_share_arbiter: stimulus queues expected done events,
// a negedge monitor pops and compares them whenever a done pulse appears.
module tb_mod12_share_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] din0, din1, len0, len1;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [3:0] count;

  mod12_share_arbiter #(.MOD(12)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .din0(din0), .din1(din1), .len0(len0), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [3:0]  cnt;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb[$];
  int          npass = 0;
  int          ntot  = 0;
  logic [31:0] cyc   = 0;
  logic        both_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (gnt0 & gnt1) both_seen = 1'b1;
    if (done0 | done1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {30'd0, done1, done0}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_outputs", {23'd0, gnt1, gnt0, done1, done0, busy, count},
              {23'd0, e.id, ~e.id, e.id, ~e.id, 1'b1, e.cnt});
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_to(input logic [31:0] t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_reset_state(input string name);
    check(name, {24'd0, gnt0, gnt1, done0, done1, busy, count}, 32'd0);
  endtask

  logic [31:0] c;

  initial begin
    rst = 1'b0; req0 = 0; req1 = 0; din0 = 0; din1 = 0; len0 = 0; len1 = 0;
    repeat (2) @(negedge clk);
    check_reset_state("reset_state");
    rst = 1'b1;

    // Single request, wrap 11->0 mid-run
    @(negedge clk); c = cyc;
    req0 = 1; din0 = 4'd10; len0 = 4'd3;
    sb.push_back('{id: 1'b0, cnt: 4'd1, cyc: c + 4});
    wait_to(c + 1); req0 = 0;
    check("t25_gnt_cnt_e1", {27'd0, gnt0, count}, {27'd0, 1'b1, 4'd10});
    wait_to(c + 2); check("t25_cnt_e2", count, 11);
    wait_to(c + 3); check("t25_cnt_e3", count, 0);
    wait_to(c + 5); check("t25_idle_e5", {30'd0, gnt0, busy}, 0);

    // Zero-length operation, din >= MOD
    @(negedge clk); c = cyc;
    req1 = 1; din1 = 4'd14; len1 = 4'd0;
    sb.push_back('{id: 1'b1, cnt: 4'd2, cyc: c + 1});
    wait_to(c + 1); req1 = 0;
    check("t26_gnt1_e1", {31'd0, gnt1}, 1);
    wait_to(c + 2); check("t26_idle_e2", {30'd0, gnt1, busy}, 0);

    // Both requests held after reset: alternation 0,1,0,1
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    check_reset_state("reset_again");
    c = cyc;
    req0 = 1; req1 = 1; din0 = 4'd3; din1 = 4'd5; len0 = 4'd2; len1 = 4'd2;
    sb.push_back('{id: 1'b0, cnt: 4'd5, cyc: c + 3});
    sb.push_back('{id: 1'b1, cnt: 4'd7, cyc: c + 7});
    sb.push_back('{id: 1'b0, cnt: 4'd5, cyc: c + 11});
    sb.push_back('{id: 1'b1, cnt: 4'd7, cyc: c + 15});
    wait_to(c + 16); req0 = 0; req1 = 0;
    wait_to(c + 18);

    // Inputs changed and request dropped mid-run are ignored
    c = cyc;
    req0 = 1; din0 = 4'd4; len0 = 4'd5;
    sb.push_back('{id: 1'b0, cnt: 4'd9, cyc: c + 6});
    wait_to(c + 2); req0 = 0; din0 = 4'd7; len0 = 4'd1;
    check("t28_busy_mid", {31'd0, busy}, 1);
    wait_to(c + 8); check("t28_idle", {30'd0, gnt0, busy}, 0);

    // Reset in the third RUN cycle aborts without a done pulse
    c = cyc;
    req0 = 1; din0 = 4'd2; len0 = 4'd6;
    wait_to(c + 1); req0 = 0;
    wait_to(c + 3); rst = 1'b0;
    wait_to(c + 4);
    check_reset_state("t29_abort");
    rst = 1'b1; req1 = 1; din1 = 4'd9; len1 = 4'd1;
    sb.push_back('{id: 1'b1, cnt: 4'd10, cyc: c + 6});
    wait_to(c + 5); req1 = 0;
    check("t29_gnt1_imm", {30'd0, gnt1, gnt0}, 2);
    wait_to(c + 8);

    // Long run wraps twice
    c = cyc;
    req0 = 1; din0 = 4'd11; len0 = 4'd15;
    sb.push_back('{id: 1'b0, cnt: 4'd2, cyc: c + 16});
    wait_to(c + 1); req0 = 0;
    check("t30_start", count, 11);
    wait_to(c + 20);

    check("sb_drained", sb.size(), 0);
    check("gnt_exclusive", {31'd0, both_seen}, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
